// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares dmem SRAM port b between the LSU (r0) and DMA/debug (r1).
// Define DMEM_ARB_RR_EN to replace fixed priority plus starvation with round robin.
module dmem_port_arbiter #(
   parameter int ADDR_W     = 12,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                r0_req,
   input  logic                r0_we,
   input  logic [ADDR_W-1:0]   r0_addr,
   input  logic [DATA_W/8-1:0] r0_be,
   input  logic [DATA_W-1:0]   r0_wdata,
   output logic                r0_gnt,
   output logic                r0_rvalid,
   output logic [DATA_W-1:0]   r0_rdata,
   input  logic                r1_req,
   input  logic                r1_we,
   input  logic [ADDR_W-1:0]   r1_addr,
   input  logic [DATA_W/8-1:0] r1_be,
   input  logic [DATA_W-1:0]   r1_wdata,
   output logic                r1_gnt,
   output logic                r1_rvalid,
   output logic [DATA_W-1:0]   r1_rdata,
   output logic                mem_enable,
   output logic                mem_wren,
   output logic [ADDR_W-1:0]   mem_address,
   output logic [DATA_W/8-1:0] mem_byteena,
   output logic [DATA_W-1:0]   mem_data,
   input  logic [DATA_W-1:0]   mem_q
);
   logic pri1;
   logic tag_v;
   logic tag_id;
`ifdef DMEM_ARB_RR_EN
   logic last;
   // r1 gets priority only when r0 won the last granted cycle
   assign pri1 = ~last;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         last <= 1'b1;
      else if (r0_gnt | r1_gnt)
         last <= r1_gnt;
`else
   localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);
   logic [7:0] starve_cnt;
   assign pri1 = starve_cnt == STARVE_LIM;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         starve_cnt <= '0;
      else if (!r1_req || r1_gnt)
         starve_cnt <= '0;
      else if (!pri1)
         starve_cnt <= starve_cnt + 8'd1;
`endif
   always_comb begin
      r1_gnt      = r1_req & (pri1 | ~r0_req);
      r0_gnt      = r0_req & ~r1_gnt;
      mem_enable  = r0_gnt | r1_gnt;
      mem_wren    = r1_gnt ? r1_we : (r0_gnt & r0_we);
      mem_address = r1_gnt ? r1_addr : r0_addr;
      mem_data    = r1_gnt ? r1_wdata : r0_wdata;
      mem_byteena = r1_gnt ? r1_be : (r0_gnt ? r0_be : '0);
      r0_rvalid   = tag_v & ~tag_id;
      r1_rvalid   = tag_v & tag_id;
      r0_rdata    = r0_rvalid ? mem_q : '0;
      r1_rdata    = r1_rvalid ? mem_q : '0;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         tag_v  <= 1'b0;
         tag_id <= 1'b0;
      end else begin
         tag_v  <= mem_enable & ~mem_wren;
         tag_id <= r1_gnt;
      end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: scoreboard bench for dmem_port_arbiter with a behavioural SRAM.
module tb_dmem_port_arbiter;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        r0_req = 1'b0, r0_we = 1'b0, r1_req = 1'b0, r1_we = 1'b0;
   logic [11:0] r0_addr = '0, r1_addr = '0;
   logic [3:0]  r0_be = '0, r1_be = '0;
   logic [31:0] r0_wdata = '0, r1_wdata = '0;
   logic        r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
   logic [31:0] r0_rdata, r1_rdata;
   logic        mem_enable, mem_wren;
   logic [11:0] mem_address;
   logic [3:0]  mem_byteena;
   logic [31:0] mem_data, mem_q;
   logic        pre_en = 1'b0;
   logic [11:0] pre_addr = '0;
   logic [31:0] pre_data = '0;
   logic [31:0] sram [4096];
   typedef struct { logic id; logic [31:0] data; int due; } exp_t;
   exp_t sb[$];
   int checks = 0;
   int errors = 0;
   int cyc = 0;

   dmem_port_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_be(r0_be), .r0_wdata(r0_wdata),
      .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
      .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_be(r1_be), .r1_wdata(r1_wdata),
      .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
      .mem_enable(mem_enable), .mem_wren(mem_wren), .mem_address(mem_address),
      .mem_byteena(mem_byteena), .mem_data(mem_data), .mem_q(mem_q)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (pre_en)
         sram[pre_addr] <= pre_data;
      else if (mem_enable) begin
         mem_q <= sram[mem_address];
         if (mem_wren)
            for (int b = 0; b < 4; b++)
               if (mem_byteena[b]) sram[mem_address][8*b +: 8] <= mem_data[8*b +: 8];
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      r0_req = 0; r0_we = 0; r0_addr = '0; r0_be = '0; r0_wdata = '0;
      r1_req = 0; r1_we = 0; r1_addr = '0; r1_be = '0; r1_wdata = '0;
   endtask

   task automatic set_r0(input logic we, input logic [11:0] a, input logic [3:0] be, input logic [31:0] d);
      r0_req = 1; r0_we = we; r0_addr = a; r0_be = be; r0_wdata = d;
   endtask

   task automatic set_r1(input logic we, input logic [11:0] a, input logic [3:0] be, input logic [31:0] d);
      r1_req = 1; r1_we = we; r1_addr = a; r1_be = be; r1_wdata = d;
   endtask

   task automatic push(input logic id, input logic [31:0] d);
      exp_t e;
      e.id = id; e.data = d; e.due = cyc + 1;
      sb.push_back(e);
   endtask

   task automatic preload(input logic [11:0] a, input logic [31:0] d);
      pre_en = 1; pre_addr = a; pre_data = d;
      tick;
      pre_en = 0;
   endtask

   task automatic monitor;
      exp_t e;
      forever begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         checks++;
         if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            if (e.id == 1'b0 && (r0_rvalid !== 1'b1 || r1_rvalid !== 1'b0 || r0_rdata !== e.data))
               begin errors++; $display("FAIL resp_r0 cyc %0d: rvalid=%b/%b rdata=%h, need 1/0 %h", cyc, r0_rvalid, r1_rvalid, r0_rdata, e.data); end
            if (e.id == 1'b1 && (r1_rvalid !== 1'b1 || r0_rvalid !== 1'b0 || r1_rdata !== e.data))
               begin errors++; $display("FAIL resp_r1 cyc %0d: rvalid=%b/%b rdata=%h, need 0/1 %h", cyc, r0_rvalid, r1_rvalid, r1_rdata, e.data); end
         end else if (r0_rvalid !== 1'b0 || r1_rvalid !== 1'b0) begin
            errors++; $display("FAIL stray_rvalid cyc %0d: rvalid=%b/%b, need 0/0", cyc, r0_rvalid, r1_rvalid);
         end
         checks++;
         if ((!r0_rvalid && r0_rdata !== 0) || (!r1_rvalid && r1_rdata !== 0))
            begin errors++; $display("FAIL rdata_gate cyc %0d: r0_rdata=%h r1_rdata=%h, need 0 when not valid", cyc, r0_rdata, r1_rdata); end
      end
   endtask

   task automatic test_reset;
      idle;
      @(negedge clk);
      checks++;
      if ({r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, mem_enable, mem_wren, mem_byteena, mem_address, mem_data, r0_rdata, r1_rdata} !== 0)
         begin errors++; $display("FAIL reset_outputs: gnt=%b%b rvalid=%b%b en=%b we=%b be=%h, need all 0", r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, mem_enable, mem_wren, mem_byteena); end
      rst_n = 1;
      tick;
   endtask

   task automatic test_r0_read;
      preload(12'h010, 32'hDEADBEEF);
      set_r0(0, 12'h010, 4'hF, 0);
      push(0, 32'hDEADBEEF);
      @(negedge clk);
      checks++;
      if (r0_gnt !== 1 || r1_gnt !== 0)
         begin errors++; $display("FAIL r0_read_gnt: gnt=%b%b, need 10", r0_gnt, r1_gnt); end
      checks++;
      if (mem_enable !== 1 || mem_wren !== 0 || mem_address !== 12'h010 || mem_byteena !== 4'hF)
         begin errors++; $display("FAIL r0_read_mem: en=%b we=%b addr=%h be=%h, need 1 0 010 f", mem_enable, mem_wren, mem_address, mem_byteena); end
      tick;
      idle;
      @(negedge clk);
      checks++;
      if (r1_rvalid !== 0)
         begin errors++; $display("FAIL r0_read_r1_rvalid: %b, need 0", r1_rvalid); end
      tick;
   endtask

   task automatic test_write_read;
      preload(12'hFFF, 32'hAABBCCDD);
      set_r1(1, 12'hFFF, 4'b0101, 32'h11223344);
      @(negedge clk);
      checks++;
      if (r1_gnt !== 1 || r0_gnt !== 0 || mem_enable !== 1 || mem_wren !== 1)
         begin errors++; $display("FAIL wr_ctrl: gnt=%b%b en=%b we=%b, need 01 1 1", r0_gnt, r1_gnt, mem_enable, mem_wren); end
      checks++;
      if (mem_address !== 12'hFFF || mem_byteena !== 4'b0101 || mem_data !== 32'h11223344)
         begin errors++; $display("FAIL wr_fields: addr=%h be=%b data=%h, need fff 0101 11223344", mem_address, mem_byteena, mem_data); end
      tick;
      set_r1(0, 12'hFFF, 4'hF, 0);
      push(1, 32'hAA22CC44);
      @(negedge clk);
      checks++;
      if (r1_gnt !== 1 || r1_rvalid !== 0)
         begin errors++; $display("FAIL rd_after_wr: gnt=%b rvalid=%b, need 1 0", r1_gnt, r1_rvalid); end
      tick;
      idle;
      @(negedge clk);
      checks++;
      if (mem_enable !== 0 || mem_byteena !== 0 || mem_wren !== 0)
         begin errors++; $display("FAIL idle_mem: en=%b we=%b be=%b, need 0 0 0", mem_enable, mem_wren, mem_byteena); end
      tick;
   endtask

`ifdef DMEM_ARB_RR_EN
   task automatic test_round_robin;
      logic e1;
      rst_n = 0;
      tick;
      rst_n = 1;
      preload(12'h020, 32'h2020);
      preload(12'h030, 32'h3030);
      set_r0(0, 12'h020, 4'hF, 0);
      set_r1(0, 12'h030, 4'hF, 0);
      e1 = 0;
      for (int i = 0; i < 12; i++) begin
         push(e1, e1 ? 32'h3030 : 32'h2020);
         @(negedge clk);
         checks++;
         if (r0_gnt !== !e1 || r1_gnt !== e1)
            begin errors++; $display("FAIL rr_gnt i=%0d: gnt=%b%b, need %b%b", i, r0_gnt, r1_gnt, !e1, e1); end
         e1 = !e1;
         tick;
      end
      idle;
      @(negedge clk);
      tick;
   endtask
`else
   task automatic test_starvation;
      int scnt;
      logic e1;
      preload(12'h020, 32'h2020);
      preload(12'h030, 32'h3030);
      set_r0(0, 12'h020, 4'hF, 0);
      set_r1(0, 12'h030, 4'hF, 0);
      scnt = 0;
      for (int i = 0; i < 27; i++) begin
         e1 = (scnt == 8);
         push(e1, e1 ? 32'h3030 : 32'h2020);
         @(negedge clk);
         checks++;
         if (r0_gnt !== !e1 || r1_gnt !== e1)
            begin errors++; $display("FAIL starve_gnt i=%0d: gnt=%b%b, need %b%b", i, r0_gnt, r1_gnt, !e1, e1); end
         scnt = e1 ? 0 : scnt + 1;
         tick;
      end
      idle;
      @(negedge clk);
      tick;
   endtask
`endif

   task automatic test_back_to_back;
      preload(12'h001, 32'h1);
      preload(12'h002, 32'h2);
      for (int i = 0; i < 8; i++) begin
         idle;
         if (i % 2 == 0) set_r0(0, 12'h001, 4'hF, 0);
         else set_r1(0, 12'h002, 4'hF, 0);
         push(1'(i % 2), (i % 2) ? 32'h2 : 32'h1);
         @(negedge clk);
         checks++;
         if (r0_gnt !== (i % 2 == 0) || r1_gnt !== (i % 2 == 1))
            begin errors++; $display("FAIL b2b_gnt i=%0d: gnt=%b%b", i, r0_gnt, r1_gnt); end
         tick;
      end
      idle;
      @(negedge clk);
      tick;
   endtask

   task automatic test_reset_mid;
      set_r0(0, 12'h010, 4'hF, 0);
      @(negedge clk);
      checks++;
      if (r0_gnt !== 1)
         begin errors++; $display("FAIL mid_gnt: r0_gnt=%b, need 1", r0_gnt); end
      tick;
      idle;
      rst_n = 0;
      repeat (2) begin
         @(negedge clk);
         checks++;
         if ({r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, mem_enable, mem_wren, mem_byteena, r0_rdata, r1_rdata} !== 0)
            begin errors++; $display("FAIL mid_reset_outputs: gnt=%b%b rvalid=%b%b en=%b rdata=%h, need all 0", r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, mem_enable, r0_rdata); end
         tick;
      end
      rst_n = 1;
      set_r0(0, 12'h010, 4'hF, 0);
      push(0, 32'hDEADBEEF);
      @(negedge clk);
      checks++;
      if (r0_gnt !== 1 || mem_enable !== 1)
         begin errors++; $display("FAIL resume_gnt: gnt=%b en=%b, need 1 1", r0_gnt, mem_enable); end
      tick;
      idle;
      @(negedge clk);
      tick;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      fork
         monitor();
      join_none
      test_reset;
      test_r0_read;
      test_write_read;
`ifdef DMEM_ARB_RR_EN
      test_round_robin;
`else
      test_starvation;
`endif
      test_back_to_back;
      test_reset_mid;
      checks++;
      if (sb.size() != 0)
         begin errors++; $display("FAIL scoreboard_drain: %0d responses outstanding, need 0", sb.size()); end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end
endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single data-memory SRAM port (port b of the dual-port `mem` wrapper: 12-bit word address, 32-bit data, 4 byte enables) between two requesters.
  - Requester 0: core load/store unit.
  - Requester 1: DMA/debug master.
- Grants at most one access per cycle, drives the active-high SRAM controls, and returns read data to the granted requester one cycle later.
- Fixed priority to requester 0, with a starvation counter that guarantees requester 1 progress.

Parameters:
- ADDR_W, 12, word address width (matches dmem depth of 4096 words).
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- STARVE_MAX, 8, consecutive cycles requester 1 may be refused before it is forced a grant (1..255).

Ports:
- clk  in  1  system clock; SRAM port clock is driven from the same net.
- rst_n  in  1  asynchronous active-low reset.
- r0_req  in  1  requester 0 access request.
- r0_we  in  1  requester 0 write (1) / read (0).
- r0_addr  in  ADDR_W  requester 0 word address.
- r0_be  in  DATA_W/8  requester 0 byte enables.
- r0_wdata  in  DATA_W  requester 0 write data.
- r0_gnt  out  1  requester 0 request accepted this cycle.
- r0_rvalid  out  1  requester 0 read data valid.
- r0_rdata  out  DATA_W  requester 0 read data.
- r1_req, r1_we, r1_addr, r1_be, r1_wdata  in  as r0  requester 1 request.
- r1_gnt, r1_rvalid, r1_rdata  out  as r0  requester 1 responses.
- mem_enable  out  1  SRAM enable (active high).
- mem_wren  out  1  SRAM write enable.
- mem_address  out  ADDR_W  SRAM word address.
- mem_byteena  out  DATA_W/8  SRAM byte enables.
- mem_data  out  DATA_W  SRAM write data.
- mem_q  in  DATA_W  SRAM read data, valid 1 cycle after enable.

Behaviour:
- Reset:
  - Asynchronous on rst_n low; all registered outputs are 0.
  - r*_rvalid = 0, starvation counter = 0, response tag = none.
  - Combinational outputs follow from the reset state.
- Grant, combinational in the request cycle:
  - If both request and starve_cnt == STARVE_MAX → grant r1.
  - Else if r0_req → grant r0.
  - Else if r1_req → grant r1.
  - Else → no grant.
  - r*_gnt is high only for the winner.
  - A requester holds req and its fields stable until it sees gnt. Held-stable stimulus is a bench assertion, not a DUT check.
- SRAM drive, combinational from the winner:
  - mem_enable = any grant.
  - mem_wren, mem_address, mem_byteena, mem_data come from the winner's fields.
  - With no grant, mem_wren = 0 and mem_byteena = 0; address and data are don't-care but held at r0's fields to limit toggling.
- Read response, fixed latency 1:
  - Register tag = {valid, id} when a granted access is a read.
  - Next cycle: r<id>_rvalid = 1 and r<id>_rdata = mem_q.
  - r*_rdata is mem_q gated to 0 when that requester's rvalid is low.
  - Writes produce no rvalid.
  - Back-to-back reads every cycle are supported: full throughput, responses in grant order.
  - Responses cannot be stalled.
- Starvation counter, 8-bit:
  - Increments when r1_req is high and r1 is not granted, saturating at STARVE_MAX.
  - Clears on any r1 grant or when r1_req is low.
- Simultaneous events:
  - A new grant in the same cycle as the previous read's rvalid is legal.
  - Read and write on the same address in consecutive cycles: the read returns SRAM content as of its own grant cycle (SRAM read-before-write not relied upon across ports).
- Reset mid-operation clears a pending rvalid; the dropped read is not reissued.

Optional Feature:
- DMEM_ARB_RR_EN defined:
  - Replaces fixed priority plus starvation with 2-way round robin.
  - A 1-bit last-winner register, reset to 1, gives priority to the requester that did not win last. It updates on every grant.
  - The starvation counter and STARVE_MAX are unused.
- DMEM_ARB_RR_EN undefined: fixed priority with starvation as above.

Test Plan:
- Reset, then r0 read addr 0x010 after preloading 0xDEADBEEF → r0_gnt same cycle, mem_enable=1, mem_wren=0; next cycle r0_rvalid=1, r0_rdata=0xDEADBEEF, r1_rvalid=0.
- r1 write addr 0xFFF, be=4'b0101, data 0x11223344; then r1 read same address over old 0xAABBCCDD → rdata=0xAA22CC44, no rvalid on the write cycle.
- r0 and r1 request continuously (fixed priority, STARVE_MAX=8) → r0 granted 8 cycles, r1 granted on the 9th, then the pattern repeats. r1_rvalid occurs exactly 1 cycle after each r1 read grant.
- Alternating r0/r1 reads every cycle to addrs 0x001/0x002 holding 0x1/0x2 → rvalid alternates, each rdata is correct, no bubbles.
- rst_n asserted low in the cycle after an r0 read grant → r0_rvalid stays 0, all outputs 0 while reset is held; normal operation resumes on release.
- DMEM_ARB_RR_EN defined, both requesting continuously → grants strictly alternate, starting with r0 after reset.
